// File: rtl/fwrisc_regfile_pkg.sv
// Shared widths, FSM states and write-request record for the fwrisc regfile write path.
package fwrisc_regfile_pkg;

  localparam int REGFILE_AWIDTH = 6;
  localparam int REGFILE_DWIDTH = 32;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } wr_state_e;

  typedef struct packed {
    logic                      valid;
    logic [REGFILE_AWIDTH-1:0] waddr;
    logic [REGFILE_DWIDTH-1:0] wdata;
  } wr_req_t;

endpackage

// File: rtl/fwrisc_rr_arb2.sv
// Two-way arbiter: round-robin when ARB_RR != 0, otherwise requester 0 has fixed priority.
module fwrisc_rr_arb2 #(
  parameter int ARB_RR = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic       r_prio1;
  logic [1:0] w_req;

  assign w_req = i_req & {2{i_en}};

  always_comb begin
    o_grant = w_req;
    if (w_req == 2'b11) begin
      o_grant = ((ARB_RR != 0) && r_prio1) ? 2'b10 : 2'b01;
    end
  end

  // A grant only goes to a valid requester, so every grant is a handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio1 <= 1'b0;
    end else if (o_grant != 2'b00) begin
      r_prio1 <= o_grant[0];
    end
  end

endmodule

// File: rtl/fwrisc_regfile_wr_ctrl.sv
// Regfile write-port controller: zero-fill sweep after reset, then arbitrated writeback.
// Optional forwarding outputs are enabled by defining FWRISC_REGFILE_WR_BYPASS_EN.
module fwrisc_regfile_wr_ctrl
  import fwrisc_regfile_pkg::*;
#(
  parameter int NUM_REGS = 64,
  parameter int ARB_RR   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [REGFILE_AWIDTH-1:0] req0_waddr,
  input  logic [REGFILE_DWIDTH-1:0] req0_wdata,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [REGFILE_AWIDTH-1:0] req1_waddr,
  input  logic [REGFILE_DWIDTH-1:0] req1_wdata,
  output logic [REGFILE_AWIDTH-1:0] rd_waddr,
  output logic [REGFILE_DWIDTH-1:0] rd_wdata,
  output logic                      rd_wen,
  output logic                      init_done
`ifdef FWRISC_REGFILE_WR_BYPASS_EN
  ,
  output logic                      byp_valid,
  output logic [REGFILE_AWIDTH-1:0] byp_addr,
  output logic [REGFILE_DWIDTH-1:0] byp_data
`endif
);

  localparam logic [REGFILE_AWIDTH-1:0] LAST_ADDR = REGFILE_AWIDTH'(NUM_REGS - 1);

  wr_state_e                 r_state;
  wr_state_e                 w_stateNext;
  logic [REGFILE_AWIDTH-1:0] r_sweepCnt;
  logic                      r_wen;
  logic [REGFILE_AWIDTH-1:0] r_waddr;
  logic [REGFILE_DWIDTH-1:0] r_wdata;
  logic                      r_initDone;
  logic                      w_run;
  logic [1:0]                w_grant;
  wr_req_t                   w_req0;
  wr_req_t                   w_req1;
  wr_req_t                   w_sel;

  assign w_req0 = '{valid: req0_valid, waddr: req0_waddr, wdata: req0_wdata};
  assign w_req1 = '{valid: req1_valid, waddr: req1_waddr, wdata: req1_wdata};
  assign w_run  = (r_state == ST_RUN);

  fwrisc_rr_arb2 #(
    .ARB_RR (ARB_RR)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_run),
    .i_req   ({req1_valid, req0_valid}),
    .o_grant (w_grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_sel       = '0;
    case (r_state)
      ST_INIT: begin
        if (r_sweepCnt == LAST_ADDR) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        if (w_grant[1]) begin
          w_sel = w_req1;
        end else if (w_grant[0]) begin
          w_sel = w_req0;
        end
      end
      default: w_stateNext = ST_INIT;
    endcase
  end

  // Idle cycles keep the last address/data so the port only toggles on real writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sweepCnt <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_initDone <= w_run;
      if (!w_run) begin
        r_wen      <= 1'b1;
        r_waddr    <= r_sweepCnt;
        r_wdata    <= '0;
        r_sweepCnt <= r_sweepCnt + REGFILE_AWIDTH'(1);
      end else begin
        r_wen <= w_sel.valid;
        if (w_sel.valid) begin
          r_waddr <= w_sel.waddr;
          r_wdata <= w_sel.wdata;
        end
      end
    end
  end

  assign rd_wen    = r_wen;
  assign rd_waddr  = r_waddr;
  assign rd_wdata  = r_wdata;
  assign init_done = r_initDone;

`ifdef FWRISC_REGFILE_WR_BYPASS_EN
  // Sweep writes are never forwarded; only accepted writeback data is.
  assign byp_valid = r_wen & r_initDone;
  assign byp_addr  = r_waddr;
  assign byp_data  = r_wdata;
`endif

endmodule
